dataframe_stream_arbiter: RTL and testbench

Frame-level round-robin arbiter that merges the AXI-Stream outputs of up to `N_CH` per-channel dataframe generators into one stream toward the DMA/PL-PS interface. Once a channel wins arbitration, its whole frame (header, ADC beats, footer, ending with TLAST) is forwarded before another channel can be granted. A beat-count watchdog guards against runaway frames. The block tags each beat with its source channel and keeps a frame counter.

---
 rtl/dataframe_stream_arbiter.sv | 135 +++++++++++++
 tb/tb_dataframe_stream_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dataframe_stream_arbiter.sv
// Frame-level round-robin arbiter merging N_CH AXI-Stream dataframe sources into one
// stream, with source tagging on TUSER, a frame counter and a beat-count watchdog.
module dataframe_stream_arbiter #(
  parameter int N_CH            = 4,
  parameter int DATA_WIDTH      = 128,
  parameter int MAX_FRAME_BEATS = 1040,
  parameter int CH_W            = $clog2(N_CH)
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  input  logic [N_CH-1:0]              CH_ENABLE,
  input  logic [N_CH*DATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [N_CH-1:0]              S_AXIS_TVALID,
  input  logic [N_CH-1:0]              S_AXIS_TLAST,
  output logic [N_CH-1:0]              S_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0]        M_AXIS_TDATA,
  output logic                         M_AXIS_TVALID,
  output logic                         M_AXIS_TLAST,
  output logic [CH_W-1:0]              M_AXIS_TUSER,
  input  logic                         M_AXIS_TREADY,
  output logic [31:0]                  FRAME_COUNT,
  output logic                         ARB_ERROR
);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

  localparam logic [15:0]     WD_LIMIT = 16'(MAX_FRAME_BEATS - 1);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(N_CH - 1);

  state_t            state_reg;
  logic [CH_W-1:0]   grant_reg;
  logic [CH_W-1:0]   last_grant_reg;
  logic [15:0]       beat_cnt_reg;
  logic [31:0]       frame_count_reg;
  logic              arb_error_reg;

  logic [DATA_WIDTH-1:0] ch_data [N_CH];
  logic [N_CH-1:0]       req;
  logic                  arb_found;
  logic [CH_W-1:0]       arb_pick;
  int                    arb_idx;
  logic                  src_valid;
  logic                  src_last;
  logic                  wd_hit;
  logic                  beat;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign ch_data[gi] = S_AXIS_TDATA[gi*DATA_WIDTH +: DATA_WIDTH];
      // Ready follows downstream while forwarding, and is forced high while discarding
      assign S_AXIS_TREADY[gi] = (grant_reg == CH_W'(gi)) &&
                                 (((state_reg == XFER) && M_AXIS_TREADY) || (state_reg == DRAIN));
    end
  endgenerate

  assign req = S_AXIS_TVALID & CH_ENABLE;

  // Rotating priority search starting just after the previous winner
  always_comb begin
    arb_found = 1'b0;
    arb_pick  = '0;
    arb_idx   = 0;
    for (int k = 1; k <= N_CH; k++) begin
      arb_idx = (int'(last_grant_reg) + k) % N_CH;
      if (!arb_found && req[arb_idx[CH_W-1:0]]) begin
        arb_found = 1'b1;
        arb_pick  = CH_W'(arb_idx);
      end
    end
  end

  assign src_valid = S_AXIS_TVALID[grant_reg];
  assign src_last  = S_AXIS_TLAST[grant_reg];
  assign wd_hit    = (beat_cnt_reg == WD_LIMIT);
  assign beat      = (state_reg == XFER) && src_valid && M_AXIS_TREADY;

  always_comb begin
    M_AXIS_TDATA  = '0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TLAST  = 1'b0;
    M_AXIS_TUSER  = '0;
    if (state_reg == XFER) begin
      M_AXIS_TDATA  = ch_data[grant_reg];
      M_AXIS_TVALID = src_valid;
      M_AXIS_TLAST  = src_last | wd_hit;
      M_AXIS_TUSER  = grant_reg;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_reg       <= IDLE;
      grant_reg       <= '0;
      last_grant_reg  <= LAST_CH;
      beat_cnt_reg    <= '0;
      frame_count_reg <= '0;
      arb_error_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          beat_cnt_reg <= '0;
          if (arb_found) begin
            grant_reg <= arb_pick;
            state_reg <= XFER;
          end
        end
        XFER: begin
          if (beat) begin
            beat_cnt_reg <= beat_cnt_reg + 16'd1;
            if (src_last) begin
              last_grant_reg  <= grant_reg;
              frame_count_reg <= frame_count_reg + 32'd1;
              state_reg       <= IDLE;
            end else if (wd_hit) begin
              // Runaway frame: close it on M and swallow the remainder of the source frame
              arb_error_reg   <= 1'b1;
              last_grant_reg  <= grant_reg;
              frame_count_reg <= frame_count_reg + 32'd1;
              state_reg       <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (src_valid && src_last) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign FRAME_COUNT = frame_count_reg;
  assign ARB_ERROR   = arb_error_reg;

endmodule

// File: tb/tb_dataframe_stream_arbiter.sv
// Randomized self-checking bench: sources are preloaded frame queues, and the expected
// merged stream is built from a frame-level round-robin model with watchdog truncation.
module tb_dataframe_stream_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MX = 8;

  typedef struct packed { logic [DW-1:0] data; logic last; } beat_t;
  typedef struct packed { logic [1:0] ch; logic [DW-1:0] data; logic last; } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    ch_en = '0;
  logic [N*DW-1:0] s_data = '0;
  logic [N-1:0]    s_valid = '0;
  logic [N-1:0]    s_last = '0;
  logic [N-1:0]    s_ready;
  logic [DW-1:0]   m_data;
  logic            m_valid;
  logic            m_last;
  logic [1:0]      m_user;
  logic            m_ready = 1'b0;
  logic [31:0]     frame_count;
  logic            arb_error;

  dataframe_stream_arbiter #(.N_CH(N), .DATA_WIDTH(DW), .MAX_FRAME_BEATS(MX)) dut (
    .ACLK(clk), .ARESETN(rst_n), .CH_ENABLE(ch_en),
    .S_AXIS_TDATA(s_data), .S_AXIS_TVALID(s_valid), .S_AXIS_TLAST(s_last),
    .S_AXIS_TREADY(s_ready), .M_AXIS_TDATA(m_data), .M_AXIS_TVALID(m_valid),
    .M_AXIS_TLAST(m_last), .M_AXIS_TUSER(m_user), .M_AXIS_TREADY(m_ready),
    .FRAME_COUNT(frame_count), .ARB_ERROR(arb_error)
  );

  always #5 clk = ~clk;

  beat_t src_q [N][$];
  beat_t mdl_q [N][$];
  int    len_q [N][$];
  exp_t  exp_q [$];
  int    model_last = N - 1;
  int    exp_frames = 0;
  logic  exp_err = 1'b0;
  int    n_checks = 0;
  int    n_fail = 0;
  int    first_fire, last_fire;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic add_frame(input int ch, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = $urandom;
      b.last = (i == len - 1);
      src_q[ch].push_back(b);
      mdl_q[ch].push_back(b);
    end
    len_q[ch].push_back(len);
  endtask

  // Whole-frame round robin over pending frames; frames longer than MX are cut at MX beats
  task automatic build_expected(input logic [N-1:0] en);
    int pick, len;
    bit found;
    beat_t b;
    exp_t e;
    while (1'b1) begin
      found = 0;
      pick  = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found && en[(model_last + k) % N] && len_q[(model_last + k) % N].size() > 0) begin
          found = 1;
          pick  = (model_last + k) % N;
        end
      end
      if (!found) break;
      len = len_q[pick].pop_front();
      for (int i = 0; i < len; i++) begin
        b = mdl_q[pick].pop_front();
        if (i < MX) begin
          e.ch   = 2'(pick);
          e.data = b.data;
          e.last = (i == len - 1) || (i == MX - 1);
          exp_q.push_back(e);
        end
      end
      exp_frames++;
      if (len > MX) exp_err = 1'b1;
      model_last = pick;
    end
  endtask

  task automatic drive_sources();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        s_valid[i] = 1'b1;
        s_data[i*DW +: DW] = src_q[i][0].data;
        s_last[i] = src_q[i][0].last;
      end else begin
        s_valid[i] = 1'b0;
        s_data[i*DW +: DW] = '0;
        s_last[i] = 1'b0;
      end
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      mdl_q[i].delete();
      len_q[i].delete();
    end
    exp_q.delete();
    drive_sources();
  endtask

  function automatic int pending_src(input logic [N-1:0] en);
    int n = 0;
    for (int i = 0; i < N; i++) if (en[i]) n += src_q[i].size();
    return n;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    m_ready = 1'b0;
    clear_all();
    model_last = N - 1;
    exp_frames = 0;
    exp_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_user", m_user, 0);
    check("rst_m_data", m_data, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_arb_error", arb_error, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // mode: 0 = ready always high, 1 = ready toggles 1,0,1,0, 2 = random ready
  task automatic run_phase(input logic [N-1:0] en, input int mode, input bit tight,
                           input int budget, input int rst_beat);
    exp_t e;
    logic [N-1:0] s_fire;
    int fires = 0;
    int after_last = 0;
    bit mid_rst = 0;
    ch_en = en;
    build_expected(en);
    first_fire = -1;
    last_fire = -1;
    drive_sources();
    m_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int cyc = 0; ; cyc++) begin
      @(negedge clk);
      s_fire = s_valid & s_ready;
      if (after_last == 1) begin
        check("gap_after_last", m_valid, 0);
        after_last = tight ? 2 : 0;
      end else if (after_last == 2) begin
        if (exp_q.size() > 0) check("rearb_one_cycle", m_valid, 1);
        after_last = 0;
      end
      check("disabled_ready", s_ready & ~ch_en, 0);
      if (m_valid) begin
        if (exp_q.size() == 0) check("unexpected_beat", m_valid, 0);
        else begin
          e = exp_q[0];
          check("tuser", m_user, e.ch);
          check("tdata", m_data, e.data);
          check("tlast", m_last, e.last);
          check("s_ready", s_ready, m_ready ? (64'd1 << e.ch) : 64'd0);
          if (m_ready) begin
            void'(exp_q.pop_front());
            fires++;
            if (first_fire < 0) first_fire = cyc;
            last_fire = cyc;
            if (m_last) after_last = 1;
          end
        end
      end
      if (rst_beat > 0 && fires == rst_beat) begin
        rst_n = 1'b0;
        #1;
        check("midrst_m_valid", m_valid, 0);
        check("midrst_s_ready", s_ready, 0);
        check("midrst_frame_count", frame_count, 0);
        check("midrst_arb_error", arb_error, 0);
        mid_rst = 1;
        break;
      end
      if (cyc >= budget) begin
        check("timeout_pending", exp_q.size() + pending_src(en), 0);
        break;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (s_fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      drive_sources();
      case (mode)
        0: m_ready = 1'b1;
        1: m_ready = ((cyc + 1) % 2 == 0);
        default: m_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (exp_q.size() == 0 && pending_src(en) == 0) break;
    end
    if (mid_rst) apply_reset();
    else begin
      check("frame_count", frame_count, exp_frames);
      check("arb_error", arb_error, exp_err);
      clear_all();
    end
    $display("phase en=%b mode=%0d beats=%0d frames=%0d err=%0d", en, mode, fires, exp_frames, exp_err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    apply_reset();

    // Single channel, 4-beat frame, first beat one cycle after TVALID
    add_frame(0, 4);
    run_phase(4'b0001, 0, 1, 50, 0);
    check("single_first_cycle", first_fire, 1);
    check("single_last_cycle", last_fire, 4);

    // Round robin, two 2-beat frames per channel
    apply_reset();
    for (int r = 0; r < 2; r++) for (int c = 0; c < N; c++) add_frame(c, 2);
    run_phase(4'b1111, 0, 1, 200, 0);

    // Enable mask 0101
    for (int c = 0; c < N; c++) begin
      add_frame(c, $urandom_range(2, 4));
      add_frame(c, $urandom_range(2, 4));
    end
    run_phase(4'b0101, 0, 1, 200, 0);

    // Backpressure on ch1's 6-beat frame
    add_frame(1, 6);
    run_phase(4'b1111, 1, 1, 100, 0);

    // Watchdog: 12-beat frame on ch2, cut at 8
    add_frame(2, 12);
    run_phase(4'b1111, 0, 0, 100, 0);

    // 1-beat frame; error flag stays sticky
    add_frame(1, 1);
    run_phase(4'b1111, 0, 0, 50, 0);

    // Reset on beat 3 of a 5-beat frame, then ch0 must win first
    add_frame(0, 5);
    run_phase(4'b1111, 0, 0, 50, 3);
    add_frame(2, 3);
    add_frame(0, 3);
    run_phase(4'b1111, 0, 1, 100, 0);

    // Randomized mixes including runaway frames and random backpressure
    for (int p = 0; p < 6; p++) begin
      for (int c = 0; c < N; c++) begin
        int nf;
        nf = $urandom_range(0, 2);
        for (int f = 0; f < nf; f++) add_frame(c, $urandom_range(1, 11));
      end
      run_phase(4'($urandom_range(1, 15)), 2, 0, 1500, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
